// File: rtl/snake_engine.sv
// Snake movement/body engine: tick divider, shift-chain body, 2-deep turn queue,
// growth, wall/wrap handling and self-collision detection.
module snake_engine #(
    parameter int MAX_LEN   = 22,
    parameter int XW        = 11,
    parameter int LW        = 6,
    parameter int CELL      = 32,
    parameter int ORIGIN    = 16,
    parameter int GRID_W    = 44,
    parameter int GRID_H    = 27,
    parameter int START_GX  = 24,
    parameter int START_GY  = 14,
    parameter int START_LEN = 1,
    parameter int TICK_DIV  = 10600000,
    parameter int WRAP      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    restart,
    input  logic                    pause,
    input  logic [3:0]              dir_req,
    input  logic                    grow,
    output logic [MAX_LEN*XW-1:0]   body_x,
    output logic [MAX_LEN*XW-1:0]   body_y,
    output logic [LW-1:0]           length,
    output logic [1:0]              dir,
    output logic                    tick,
    output logic                    dead,
    output logic                    full
);

    localparam int DW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GPW = $clog2(MAX_LEN + 1);

    localparam logic [XW-1:0]  X_MIN     = XW'(ORIGIN);
    localparam logic [XW-1:0]  X_MAX     = XW'(ORIGIN + (GRID_W - 1) * CELL);
    localparam logic [XW-1:0]  Y_MIN     = XW'(ORIGIN);
    localparam logic [XW-1:0]  Y_MAX     = XW'(ORIGIN + (GRID_H - 1) * CELL);
    localparam logic [XW-1:0]  STEP      = XW'(CELL);
    localparam logic [XW-1:0]  Y_START   = XW'(ORIGIN + START_GY * CELL);
    localparam logic [LW-1:0]  LEN_MAX   = LW'(MAX_LEN);
    localparam logic [LW-1:0]  LEN_START = LW'(START_LEN);
    localparam logic [GPW-1:0] GP_MAX    = GPW'(MAX_LEN);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // Start column of segment i, trailing left of the head and clamped at the wall.
    function automatic logic [XW-1:0] init_x(input int idx);
        if (idx >= START_GX) begin
            init_x = X_MIN;
        end else begin
            init_x = XW'(ORIGIN + (START_GX - idx) * CELL);
        end
    endfunction

    state_t          state_r, state_nx_s;
    logic [XW-1:0]   seg_x_r [MAX_LEN];
    logic [XW-1:0]   seg_y_r [MAX_LEN];
    logic [XW-1:0]   seg_x_nx_s [MAX_LEN];
    logic [XW-1:0]   seg_y_nx_s [MAX_LEN];
    logic [LW-1:0]   len_r, len_nx_s, hit_lim_s;
    logic [1:0]      dir_r, dir_nx_s, q0_r, q0_nx_s, q1_r, q1_nx_s;
    logic [1:0]      qcnt_r, qcnt_nx_s, qcnt_pop_s;
    logic [DW-1:0]   div_r, div_nx_s;
    logic [GPW-1:0]  gp_r, gp_nx_s, gp_pop_s;
    logic [3:0]      req_prev_r, rise_s;
    logic            tick_r, tick_nx_s, dead_r, full_r;
    logic            onehot_s, req_valid_s, accept_s, push_s;
    logic [1:0]      req_dir_s, ref_dir_s, move_dir_s;
    logic [XW-1:0]   head_x_s, head_y_s;
    logic            tick_ev_s, edge_s, growing_s, hit_s, die_s, commit_s;

    // Turn request decode and queue acceptance.
    always_comb begin
        rise_s      = dir_req & ~req_prev_r;
        onehot_s    = (dir_req != 4'b0000) && ((dir_req & (dir_req - 4'b0001)) == 4'b0000);
        req_valid_s = onehot_s && (rise_s != 4'b0000);
        case (dir_req)
            4'b0001: req_dir_s = 2'd3;
            4'b0010: req_dir_s = 2'd2;
            4'b0100: req_dir_s = 2'd0;
            4'b1000: req_dir_s = 2'd1;
            default: req_dir_s = 2'd0;
        endcase
        case (qcnt_r)
            2'd0:    ref_dir_s = dir_r;
            2'd1:    ref_dir_s = q0_r;
            default: ref_dir_s = q1_r;
        endcase
        // In IDLE a request matching the default heading just starts the game.
        accept_s = req_valid_s && (state_r != ST_DEAD)
                && (req_dir_s != (ref_dir_s ^ 2'd2))
                && ((req_dir_s != ref_dir_s) || (state_r == ST_IDLE));
        push_s   = accept_s && (req_dir_s != ref_dir_s) && (qcnt_r != 2'd2);
    end

    // Candidate head position, edge/self-hit tests for the current tick.
    always_comb begin
        tick_ev_s  = (state_r == ST_RUN) && !pause && (div_r == DIV_LAST);
        move_dir_s = (qcnt_r != 2'd0) ? q0_r : dir_r;
        head_x_s   = seg_x_r[0];
        head_y_s   = seg_y_r[0];
        edge_s     = 1'b0;
        case (move_dir_s)
            2'd0: begin
                if (seg_x_r[0] >= X_MAX) begin
                    edge_s   = 1'b1;
                    head_x_s = X_MIN;
                end else begin
                    head_x_s = seg_x_r[0] + STEP;
                end
            end
            2'd1: begin
                if (seg_y_r[0] >= Y_MAX) begin
                    edge_s   = 1'b1;
                    head_y_s = Y_MIN;
                end else begin
                    head_y_s = seg_y_r[0] + STEP;
                end
            end
            2'd2: begin
                if (seg_x_r[0] <= X_MIN) begin
                    edge_s   = 1'b1;
                    head_x_s = X_MAX;
                end else begin
                    head_x_s = seg_x_r[0] - STEP;
                end
            end
            default: begin
                if (seg_y_r[0] <= Y_MIN) begin
                    edge_s   = 1'b1;
                    head_y_s = Y_MAX;
                end else begin
                    head_y_s = seg_y_r[0] - STEP;
                end
            end
        endcase
        growing_s = (gp_r != GPW'(0)) && (len_r < LEN_MAX);
        // The old tail vacates on a plain move, so it is only a hazard while growing.
        hit_lim_s = growing_s ? len_r : (len_r - LW'(1));
        hit_s     = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            hit_s = hit_s | ((LW'(i) < hit_lim_s)
                          && (seg_x_r[i] == head_x_s) && (seg_y_r[i] == head_y_s));
        end
        die_s    = tick_ev_s && ((edge_s && (WRAP == 0)) || hit_s);
        commit_s = tick_ev_s && !die_s;
    end

    // FSM next state.
    always_comb begin
        state_nx_s = state_r;
        if (restart) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nx_s = accept_s ? ST_RUN : ST_IDLE;
                ST_RUN:  state_nx_s = die_s ? ST_DEAD : ST_RUN;
                ST_DEAD: state_nx_s = ST_DEAD;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: divider, queue, body shift and growth.
    always_comb begin
        seg_x_nx_s = seg_x_r;
        seg_y_nx_s = seg_y_r;
        len_nx_s   = len_r;
        dir_nx_s   = dir_r;
        q0_nx_s    = q0_r;
        q1_nx_s    = q1_r;
        qcnt_nx_s  = qcnt_r;
        qcnt_pop_s = qcnt_r;
        div_nx_s   = div_r;
        gp_nx_s    = gp_r;
        gp_pop_s   = gp_r;
        tick_nx_s  = 1'b0;
        if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_nx_s[i] = init_x(i);
                seg_y_nx_s[i] = Y_START;
            end
            len_nx_s  = LEN_START;
            dir_nx_s  = 2'd0;
            q0_nx_s   = 2'd0;
            q1_nx_s   = 2'd0;
            qcnt_nx_s = 2'd0;
            div_nx_s  = DW'(0);
            gp_nx_s   = GPW'(0);
        end else begin
            if ((state_r == ST_RUN) && !pause) begin
                div_nx_s = tick_ev_s ? DW'(0) : (div_r + DW'(1));
            end else begin
                div_nx_s = div_r;
            end
            if (commit_s && (qcnt_r != 2'd0)) begin
                dir_nx_s   = q0_r;
                q0_nx_s    = q1_r;
                qcnt_pop_s = qcnt_r - 2'd1;
            end else begin
                qcnt_pop_s = qcnt_r;
            end
            if (push_s) begin
                if (qcnt_pop_s == 2'd0) begin
                    q0_nx_s = req_dir_s;
                end else begin
                    q1_nx_s = req_dir_s;
                end
                qcnt_nx_s = qcnt_pop_s + 2'd1;
            end else begin
                qcnt_nx_s = qcnt_pop_s;
            end
            if (commit_s) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x_nx_s[i] = seg_x_r[i-1];
                    seg_y_nx_s[i] = seg_y_r[i-1];
                end
                seg_x_nx_s[0] = head_x_s;
                seg_y_nx_s[0] = head_y_s;
                tick_nx_s     = 1'b1;
            end else begin
                tick_nx_s = 1'b0;
            end
            if (commit_s && growing_s) begin
                len_nx_s = len_r + LW'(1);
                gp_pop_s = gp_r - GPW'(1);
            end else begin
                len_nx_s = len_r;
                gp_pop_s = gp_r;
            end
            if (grow && (gp_pop_s < GP_MAX)) begin
                gp_nx_s = gp_pop_s + GPW'(1);
            end else begin
                gp_nx_s = gp_pop_s;
            end
            if (len_nx_s == LEN_MAX) begin
                gp_nx_s = GPW'(0);
            end else begin
                gp_nx_s = gp_nx_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_r[i] <= init_x(i);
                seg_y_r[i] <= Y_START;
            end
            len_r      <= LEN_START;
            dir_r      <= 2'd0;
            q0_r       <= 2'd0;
            q1_r       <= 2'd0;
            qcnt_r     <= 2'd0;
            div_r      <= DW'(0);
            gp_r       <= GPW'(0);
            req_prev_r <= 4'b0000;
            tick_r     <= 1'b0;
            dead_r     <= 1'b0;
            full_r     <= (LEN_START == LEN_MAX);
        end else begin
            seg_x_r    <= seg_x_nx_s;
            seg_y_r    <= seg_y_nx_s;
            len_r      <= len_nx_s;
            dir_r      <= dir_nx_s;
            q0_r       <= q0_nx_s;
            q1_r       <= q1_nx_s;
            qcnt_r     <= qcnt_nx_s;
            div_r      <= div_nx_s;
            gp_r       <= gp_nx_s;
            req_prev_r <= dir_req;
            tick_r     <= tick_nx_s;
            dead_r     <= (state_nx_s == ST_DEAD);
            full_r     <= (len_nx_s == LEN_MAX);
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign body_x[g*XW +: XW] = seg_x_r[g];
        assign body_y[g*XW +: XW] = seg_y_r[g];
    end

    assign length = len_r;
    assign dir    = dir_r;
    assign tick   = tick_r;
    assign dead   = dead_r;
    assign full   = full_r;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: one wrapping and one wall-death instance share stimulus.
module tb_snake_engine;

    localparam int ML = 8;
    localparam int XW = 11;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst, restart, pause, grow;
    logic [3:0] dir_req;

    logic [ML*XW-1:0] bx_w, by_w, bx_n, by_n;
    logic [LW-1:0]    len_w, len_n;
    logic [1:0]       dir_w, dir_n;
    logic             tick_w, dead_w, full_w, tick_n, dead_n, full_n;

    int n_checks = 0;
    int n_errors = 0;
    int seen, cyc;

    always #5 clk = ~clk;

    snake_engine #(.MAX_LEN(ML), .XW(XW), .LW(LW), .CELL(32), .ORIGIN(16), .GRID_W(8),
                   .GRID_H(8), .START_GX(3), .START_GY(3), .START_LEN(3), .TICK_DIV(4),
                   .WRAP(1)) u_w (
        .clk(clk), .rst(rst), .restart(restart), .pause(pause), .dir_req(dir_req),
        .grow(grow), .body_x(bx_w), .body_y(by_w), .length(len_w), .dir(dir_w),
        .tick(tick_w), .dead(dead_w), .full(full_w));

    snake_engine #(.MAX_LEN(ML), .XW(XW), .LW(LW), .CELL(32), .ORIGIN(16), .GRID_W(8),
                   .GRID_H(8), .START_GX(3), .START_GY(3), .START_LEN(3), .TICK_DIV(4),
                   .WRAP(0)) u_n (
        .clk(clk), .rst(rst), .restart(restart), .pause(pause), .dir_req(dir_req),
        .grow(grow), .body_x(bx_n), .body_y(by_n), .length(len_n), .dir(dir_n),
        .tick(tick_n), .dead(dead_n), .full(full_n));

    function automatic int seg(input logic [ML*XW-1:0] v, input int i);
        return int'(v[i*XW +: XW]);
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tick_w || dead_w) && (n < 40));
        check_val("tick_wait", int'(tick_w || dead_w), 1);
        c = n;
    endtask

    task automatic idle(input int n, output int s);
        s = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tick_w) s++;
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_val("rs_hx", seg(bx_w, 0), 112);
        check_val("rs_hy", seg(by_w, 0), 112);
        check_val("rs_len", int'(len_w), 3);
        check_val("rs_dead_w", int'(dead_w), 0);
        check_val("rs_dead_n", int'(dead_n), 0);
        check_val("rs_dir", int'(dir_w), 0);
        check_val("rs_dir_n", int'(dir_n), 0);
    endtask

    task automatic pulse_grow(input int n);
        for (int i = 0; i < n; i++) begin
            grow = 1'b1;
            @(negedge clk);
            grow = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic request(input logic [3:0] r);
        dir_req = r;
        @(negedge clk);
        dir_req = 4'b0000;
    endtask

    initial begin
        rst = 1'b0; restart = 1'b0; pause = 1'b0; grow = 1'b0; dir_req = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset state and idle behaviour
        idle(40, seen);
        check_val("idle_ticks", seen, 0);
        check_val("reset_hx", seg(bx_w, 0), 112);
        check_val("reset_hy", seg(by_w, 0), 112);
        check_val("reset_s1x", seg(bx_w, 1), 80);
        check_val("reset_s3x", seg(bx_w, 3), 16);
        check_val("reset_s7x", seg(bx_w, 7), 16);
        check_val("reset_len", int'(len_w), 3);
        check_val("reset_dir", int'(dir_w), 0);
        check_val("reset_dead", int'(dead_w), 0);
        check_val("reset_full", int'(full_w), 0);
        check_val("reset_full_n", int'(full_n), 0);

        // Straight run right, pause, then the right wall
        request(4'b0100);
        wait_tick(cyc);
        check_val("first_tick_lat", cyc, 4);
        check_val("t1_hx", seg(bx_w, 0), 144);
        check_val("t1_s1x", seg(bx_w, 1), 112);
        wait_tick(cyc);
        check_val("tick_period", cyc, 4);
        check_val("t2_hx", seg(bx_w, 0), 176);
        check_val("t2_s1x", seg(bx_w, 1), 144);
        pause = 1'b1;
        idle(8, seen);
        check_val("pause_ticks", seen, 0);
        check_val("pause_hx", seg(bx_w, 0), 176);
        pause = 1'b0;
        wait_tick(cyc);
        check_val("t3_hx", seg(bx_w, 0), 208);
        check_val("t3_s1x", seg(bx_w, 1), 176);
        wait_tick(cyc);
        check_val("t4_hx", seg(bx_w, 0), 240);
        wait_tick(cyc);
        check_val("wrap_hx", seg(bx_w, 0), 16);
        check_val("wrap_tick", int'(tick_w), 1);
        check_val("wrap_dead", int'(dead_w), 0);
        check_val("wall_dead", int'(dead_n), 1);
        check_val("wall_tick", int'(tick_n), 0);
        check_val("wall_hx", seg(bx_n, 0), 240);
        check_val("wall_len", int'(len_n), 3);

        // Turn queue: up, left queued; down dropped (full); reverse and multi-hot ignored
        do_restart();
        dir_req = 4'b0100;
        @(negedge clk); dir_req = 4'b0001;
        @(negedge clk); dir_req = 4'b0010;
        @(negedge clk); dir_req = 4'b1000;
        @(negedge clk); dir_req = 4'b0000;
        wait_tick(cyc);
        check_val("q1_dir", int'(dir_w), 3);
        check_val("q1_hx", seg(bx_w, 0), 112);
        check_val("q1_hy", seg(by_w, 0), 80);
        wait_tick(cyc);
        check_val("q2_dir", int'(dir_w), 2);
        check_val("q2_hx", seg(bx_w, 0), 80);
        check_val("q2_hy", seg(by_w, 0), 80);
        wait_tick(cyc);
        check_val("qfull_dir", int'(dir_w), 2);
        check_val("qfull_hx", seg(bx_w, 0), 48);
        dir_req = 4'b0100;
        @(negedge clk); dir_req = 4'b1001;
        @(negedge clk); dir_req = 4'b0000;
        wait_tick(cyc);
        check_val("rev_dir", int'(dir_w), 2);
        check_val("rev_hx", seg(bx_w, 0), 16);
        check_val("rev_hy", seg(by_w, 0), 80);

        // Growth to full, then saturation
        do_restart();
        pulse_grow(5);
        check_val("grow_idle_len", int'(len_w), 3);
        request(4'b0100);
        for (int k = 1; k <= 4; k++) wait_tick(cyc);
        check_val("g4_len", int'(len_w), 7);
        check_val("g4_full", int'(full_w), 0);
        wait_tick(cyc);
        check_val("g5_len", int'(len_w), 8);
        check_val("g5_full", int'(full_w), 1);
        check_val("g5_hx", seg(bx_w, 0), 16);
        check_val("g5_dead", int'(dead_w), 0);
        pulse_grow(1);
        wait_tick(cyc);
        check_val("g6_len", int'(len_w), 8);
        check_val("g6_hx", seg(bx_w, 0), 48);
        check_val("g6_dead", int'(dead_w), 0);
        check_val("g6_full", int'(full_w), 1);

        // Self-collision: length 5, right -> down -> left -> up
        do_restart();
        pulse_grow(2);
        request(4'b0100);
        wait_tick(cyc);
        wait_tick(cyc);
        check_val("sc_len", int'(len_w), 5);
        check_val("sc_hx", seg(bx_w, 0), 176);
        request(4'b1000);
        wait_tick(cyc);
        check_val("sc_down_hx", seg(bx_w, 0), 176);
        check_val("sc_down_hy", seg(by_w, 0), 144);
        request(4'b0010);
        wait_tick(cyc);
        check_val("sc_left_hx", seg(bx_w, 0), 144);
        check_val("sc_left_hy", seg(by_w, 0), 144);
        request(4'b0001);
        wait_tick(cyc);
        check_val("sc_dead", int'(dead_w), 1);
        check_val("sc_tick", int'(tick_w), 0);
        check_val("sc_hx", seg(bx_w, 0), 144);
        check_val("sc_hy", seg(by_w, 0), 144);
        check_val("sc_dlen", int'(len_w), 5);
        idle(10, seen);
        check_val("dead_ticks", seen, 0);
        check_val("dead_hold", int'(dead_w), 1);
        check_val("dead_hx", seg(bx_w, 0), 144);
        do_restart();
        check_val("rs_s2x", seg(bx_w, 2), 48);
        idle(12, seen);
        check_val("rs_idle_ticks", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
